// File: rtl/demux1x8_32bits_buf_if.sv
`default_nettype none
// ============================================================================
//  Module   : demux1x8_32bits_buf_if
//  Brief    : Producer/consumer bundle for the buffered 1-to-8 word demux.
//  Revision : 1.0  initial release
// ============================================================================
interface demux1x8_32bits_buf_if #(
   parameter int WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     in_data;
   logic [2:0]           select;
   logic                 auto_mode;
   logic [7:0]           out_valid;
   logic [7:0]           out_ready;
   logic [8*WIDTH-1:0]   out_data;
   logic [2:0]           ptr;
   logic [15:0]          accept_count;

   modport master (
      output in_valid, in_data, select, auto_mode, out_ready,
      input  in_ready, out_valid, out_data, ptr, accept_count
   );

   modport slave (
      input  in_valid, in_data, select, auto_mode, out_ready,
      output in_ready, out_valid, out_data, ptr, accept_count
   );
endinterface
`default_nettype wire

// File: rtl/demux1x8_32bits_buf.sv
`default_nettype none
// ============================================================================
//  Module   : demux1x8_32bits_buf
//  Brief    : Steers each accepted word into one of eight one-entry channel
//             registers, by explicit select or a round-robin pointer.
//  Revision : 1.0  initial release
// ============================================================================
module demux1x8_32bits_buf #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             rst_n,
   demux1x8_32bits_buf_if.slave  bus
);
   localparam int c_chans = 8;

   logic [2:0]  w_target;
   logic        w_ready;
   logic        w_acc;
   logic [7:0]  w_valid;
   logic [2:0]  r_ptr;
   logic [15:0] r_count;

   assign w_target = bus.auto_mode ? r_ptr : bus.select;
   // A full target still accepts when its consumer drains it this cycle.
   assign w_ready  = ~w_valid[w_target] | bus.out_ready[w_target];
   assign w_acc    = bus.in_valid & w_ready;

   generate
      for (genvar k = 0; k < c_chans; k++) begin : g_chan
         logic             r_vld;
         logic [WIDTH-1:0] r_data;
         logic             w_load;

         assign w_load = w_acc && (w_target == 3'(k));

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               r_vld  <= 1'b0;
               r_data <= '0;
            end else if (w_load) begin
               r_vld  <= 1'b1;
               r_data <= bus.in_data;
            end else if (r_vld && bus.out_ready[k]) begin
               r_vld  <= 1'b0;
            end
         end

         assign w_valid[k]                     = r_vld;
         assign bus.out_data[WIDTH*k +: WIDTH] = r_data;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ptr   <= 3'd0;
         r_count <= 16'd0;
      end else if (w_acc) begin
         r_count <= r_count + 16'd1;
         if (bus.auto_mode) begin
            r_ptr <= r_ptr + 3'd1;
         end
      end
   end

   assign bus.in_ready     = w_ready;
   assign bus.out_valid    = w_valid;
   assign bus.ptr          = r_ptr;
   assign bus.accept_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_demux1x8_32bits_buf.sv
`default_nettype none
// ============================================================================
//  Module   : tb_demux1x8_32bits_buf
//  Brief    : Self-checking bench: vector table, corner sequences, random run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_demux1x8_32bits_buf;
   localparam int WIDTH = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   demux1x8_32bits_buf_if #(.WIDTH(WIDTH)) bus ();
   demux1x8_32bits_buf #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0;
   int failures = 0;

   // Reference state: what each channel holds, plus pointer and counter.
   bit          m_valid [8];
   logic [31:0] m_data  [8];
   int          m_ptr;
   int          m_count;

   typedef struct {
      logic [31:0] data;
      logic [2:0]  sel;
      bit          exp_ready;
      logic [7:0]  exp_valid;
   } vec_t;
   vec_t vecs [9];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic int m_target();
      return bus.auto_mode ? m_ptr : int'(bus.select);
   endfunction

   function automatic bit m_ready();
      int t = m_target();
      return !m_valid[t] || bus.out_ready[t];
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 8; k++) begin
         m_valid[k] = 1'b0;
         m_data[k]  = 32'd0;
      end
      m_ptr   = 0;
      m_count = 0;
   endtask

   task automatic drive(input bit iv, input logic [31:0] d, input logic [2:0] sel,
                        input bit am, input logic [7:0] ordy);
      bus.in_valid  = iv;
      bus.in_data   = d;
      bus.select    = sel;
      bus.auto_mode = am;
      bus.out_ready = ordy;
   endtask

   function automatic logic [31:0] chan(input int k);
      logic [8*WIDTH-1:0] all = bus.out_data;
      return all[WIDTH*k +: WIDTH];
   endfunction

   task automatic compare_state();
      logic [7:0] v;
      for (int k = 0; k < 8; k++) v[k] = m_valid[k];
      check("out_valid", bus.out_valid, v);
      for (int k = 0; k < 8; k++) check($sformatf("out_data%0d", k), chan(k), m_data[k]);
      check("ptr", bus.ptr, m_ptr[2:0]);
      check("accept_count", bus.accept_count, m_count[15:0]);
   endtask

   // Inputs already driven; check in_ready, advance model and DUT one edge.
   task automatic step();
      int t;
      bit acc;
      #1;
      check("in_ready", bus.in_ready, m_ready());
      t   = m_target();
      acc = bus.in_valid && m_ready();
      for (int k = 0; k < 8; k++)
         if (m_valid[k] && bus.out_ready[k]) m_valid[k] = 1'b0;
      if (acc) begin
         m_valid[t] = 1'b1;
         m_data[t]  = bus.in_data;
         m_count    = (m_count + 1) % 65536;
         if (bus.auto_mode) m_ptr = (m_ptr + 1) % 8;
      end
      if (!rst_n) model_clear();
      @(posedge clk);
      #1;
      compare_state();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive(1'b0, 32'd0, 3'd0, 1'b0, 8'h00);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      // Reset with in_valid held high for two cycles: nothing may be captured.
      model_clear();
      rst_n = 1'b0;
      drive(1'b1, 32'hDEADBEEF, 3'd1, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      compare_state();
      rst_n = 1'b1;
      drive(1'b0, 32'd0, 3'd0, 1'b0, 8'h00);
      #1;
      check("ready_after_reset", bus.in_ready, 1'b1);

      // Explicit select fill, then a blocked ninth word.
      for (int k = 0; k < 8; k++) begin
         vecs[k].data      = 32'hA000_0000 + 32'(k);
         vecs[k].sel       = 3'(k);
         vecs[k].exp_ready = 1'b1;
         vecs[k].exp_valid = 8'((16'd1 << (k + 1)) - 16'd1);
      end
      vecs[8].data = 32'h9999_9999; vecs[8].sel = 3'd3;
      vecs[8].exp_ready = 1'b0; vecs[8].exp_valid = 8'hFF;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, vecs[i].data, vecs[i].sel, 1'b0, 8'h00);
         #1;
         check($sformatf("tbl_ready%0d", i), bus.in_ready, vecs[i].exp_ready);
         step();
         check($sformatf("tbl_valid%0d", i), bus.out_valid, vecs[i].exp_valid);
      end
      check("tbl_ch3", chan(3), 32'hA000_0003);
      check("tbl_count", bus.accept_count, 16'd8);
      check("tbl_ptr", bus.ptr, 3'd0);

      // Same-cycle drain and refill on channel 5.
      drive(1'b1, 32'h1111_1111, 3'd5, 1'b0, 8'h20);
      step();
      drive(1'b1, 32'h2222_2222, 3'd5, 1'b0, 8'h20);
      #1;
      check("refill_ready", bus.in_ready, 1'b1);
      step();
      check("refill_valid5", bus.out_valid[5], 1'b1);
      check("refill_data5", chan(5), 32'h2222_2222);

      // Round-robin wrap from a fresh reset.
      do_reset();
      for (int w = 1; w <= 10; w++) begin
         drive(1'b1, 32'(w), 3'd7, 1'b1, 8'hFF);
         step();
      end
      check("rr_ch0", chan(0), 32'd9);
      check("rr_ch1", chan(1), 32'd10);
      check("rr_ch7", chan(7), 32'd8);
      check("rr_ptr", bus.ptr, 3'd2);
      check("rr_count", bus.accept_count, 16'd10);

      // Backpressure in auto mode at ptr=4.
      drive(1'b1, 32'h0202, 3'd0, 1'b1, 8'hFF); step();
      drive(1'b1, 32'h0303, 3'd0, 1'b1, 8'hFF); step();
      drive(1'b1, 32'h0044, 3'd4, 1'b0, 8'h00); step();
      drive(1'b1, 32'h0055, 3'd0, 1'b1, 8'h00);
      #1;
      check("bp_ready", bus.in_ready, 1'b0);
      step();
      check("bp_ptr_hold", bus.ptr, 3'd4);
      check("bp_data_hold", chan(4), 32'h0044);
      drive(1'b1, 32'h0055, 3'd0, 1'b1, 8'h10);
      step();
      check("bp_ptr_adv", bus.ptr, 3'd5);
      check("bp_data_new", chan(4), 32'h0055);

      // Mode switch: explicit word leaves ptr alone, auto resumes at ptr.
      drive(1'b1, 32'h0066, 3'd0, 1'b1, 8'hFF); step();
      drive(1'b1, 32'h0077, 3'd2, 1'b0, 8'h00); step();
      check("ms_ch2", chan(2), 32'h0077);
      check("ms_ptr_hold", bus.ptr, 3'd6);
      drive(1'b1, 32'h0088, 3'd2, 1'b1, 8'h00); step();
      check("ms_ch6", chan(6), 32'h0088);
      check("ms_ptr_adv", bus.ptr, 3'd7);

      // Reset mid-operation with an offered word.
      rst_n = 1'b0;
      drive(1'b1, 32'hCAFE_F00D, 3'd1, 1'b0, 8'h00);
      step();
      rst_n = 1'b1;
      check("midrst_valid", bus.out_valid, 8'h00);
      check("midrst_count", bus.accept_count, 16'd0);

      // Random traffic against the reference model.
      for (int n = 0; n < 800; n++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
               1'($urandom_range(0, 1)), 8'($urandom));
         step();
      end
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
